rr_onehot_arbiter: RTL

//   Round-robin arbiter that shares one downstream resource among N requesters.
//   - Grant vector is registered and always zero or one-hot.
//   - Grant holds while the owner keeps requesting, with a hold-time limit.
//   - Emits an encoded grant index, a valid flag and a one-hot-violation flag.

---
 rtl/rr_onehot_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a hold-time limit,
// an encoded grant index and a registered one-hot violation flag.
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             onehot_err,
  output logic             dbg_state_o
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Handshake: req is a level; a requester owns the resource for every cycle
  // its gnt bit is high and must keep req high for as long as it wants it.
  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             onehot_err_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W:0]   scan_pos;
  logic             release_now;

  // Circular scan starting at ptr_q: first set request wins.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    scan_pos   = '0;
    for (int i = 0; i < N; i++) begin
      scan_pos = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (scan_pos >= (IDX_W + 1)'(N)) begin
        scan_pos = scan_pos - (IDX_W + 1)'(N);
      end
      if (!pick_found && req[scan_pos[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_pos[IDX_W-1:0];
      end
    end
  end

  assign release_now = !req[gnt_idx_q] ||
                       ((hold_cnt_q == HW'(MAX_HOLD)) && (|(req & ~gnt_q)));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_idx_d       = pick_idx;
          hold_cnt_d      = HW'(1);
          state_d         = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d      = '0;
          gnt_idx_d  = '0;
          hold_cnt_d = '0;
          ptr_d      = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
          state_d    = IDLE;
        end else if (hold_cnt_q != HW'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      hold_cnt_q   <= '0;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      onehot_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      onehot_err_q <= ($countones(gnt_q) > 1);
    end
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = |gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign onehot_err  = onehot_err_q;
  assign dbg_state_o = (state_q == GRANT);

endmodule
